bsg_fifo_bypass_small: RTL

// Zero-latency bypassing buffer: successor to the enable/bypass register,

---
 rtl/bsg_fifo_bypass_small.sv | 99 +++++++++
 1 files changed

// File: rtl/bsg_fifo_bypass_small.sv
// bsg_fifo_bypass_small
// Zero-latency bypassing FIFO with a valid/ready input and a valid/yumi output.
// When the buffer is empty, input data reaches the output in the same cycle.
// Data the consumer does not take that cycle is held in an els_p-deep
// circular buffer and then drains in strict FIFO order.
module bsg_fifo_bypass_small #(
  parameter int width_p = 128,
  parameter int els_p   = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  // A one-entry buffer still gets a one-bit pointer; it simply never leaves 0.
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [width_p-1:0]  mem_q [els_p];
  logic [width_p-1:0]  head_data;

  logic empty;
  logic full;
  logic enq;
  logic deq;

  // Handshake decode: ready depends only on occupancy, bypassed data is never written.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == full_cnt_lp);
    ready_o = ~full;
    v_o     = ~empty | v_i;
    enq     = v_i & ~full & ~(empty & yumi_i);
    deq     = yumi_i & ~empty;
    count_o = count_q;
  end

  // Head-of-queue read; a compare mux keeps non-power-of-two depths in range.
  always_comb begin
    head_data = mem_q[0];
    for (int i = 0; i < els_p; i++) begin
      if (rptr_q == ptr_w_lp'(i)) begin
        head_data = mem_q[i];
      end
    end
  end

  // Output mux: pass the producer straight through while nothing is buffered.
  always_comb begin
    data_o = empty ? data_i : head_data;
  end

  // Next-state for pointers and occupancy, with explicit wrap at els_p-1.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    if (deq) begin
      rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + ptr_w_lp'(1);
    end
    if (enq) begin
      wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + ptr_w_lp'(1);
    end
  end

  // Control state; reset drops every buffered entry immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage array is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if (enq && (wptr_q == ptr_w_lp'(i))) begin
        mem_q[i] <= data_i;
      end
    end
  end

endmodule
